mem_port_arbiter: RTL and testbench

Shares one single-port memory between the core's instruction-fetch and data-memory interfaces, which use a req/ready/err handshake. Arbitrates with fixed data-side priority and an anti-starvation limit for fetch. Supervises each transaction with a timeout counter. Sits between the RV32I core and the on-chip SRAM/bus bridge.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_timeout.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Contents:
//   arb_state_t        - arbiter FSM states
//   OWNER_IMEM/DMEM    - encoding of the owner output
//   DEF_*              - default parameter values
//   cnt_w()            - counter width able to hold 0..max_val (never below 1 bit)
package mem_arb_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;
  localparam int DEF_IMEM_MAX_WAIT  = 4;

  localparam logic OWNER_IMEM = 1'b0;
  localparam logic OWNER_DMEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // A zero limit would give a zero-width counter; keep at least one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Transaction watchdog: loadable up-counter with enable, clear and an expiry flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous clear to 0 (highest priority after reset)
//   load       - synchronous load of load_val
//   load_val   - value for load
//   en         - count up by one (saturates at all-ones)
//   expired    - count has reached LIMIT-1; never set when LIMIT is 0
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES,
  parameter int W     = cnt_w(LIMIT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  // Expiry is flagged on the last allowed cycle so the owner can be answered
  // in that same cycle rather than one cycle late.
  localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (LIMIT > 0) && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (imem) and data
// (dmem) requesters. Data side has fixed priority; fetch is forced through
// after IMEM_MAX_WAIT consecutive contested losses. Each grant is watched by
// a timeout that answers the owner with an error if memory never responds.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; sample requests and pick the winner for next cycle
//   GRANT_I | fetch owns the memory; wait for mem_ready or timeout
//   GRANT_D | data side owns the memory; wait for mem_ready or timeout
//
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   imem_req/addr                  - fetch request (read only)
//   imem_rdata/ready/err           - fetch response, one-cycle ready pulse
//   dmem_req/we/be/addr/wdata      - data request
//   dmem_rdata/ready/err           - data response, one-cycle ready pulse
//   mem_req/we/be/addr/wdata       - request to memory, driven from the owner
//   mem_rdata/ready/err            - memory response
//   busy                           - a grant is active
//   owner                          - 0 = imem, 1 = dmem (valid while busy)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int IMEM_MAX_WAIT  = DEF_IMEM_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  output logic                imem_err,

  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [DATA_W/8-1:0] dmem_be,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_err,

  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                mem_err,

  output logic                busy,
  output logic                owner
);

  localparam int                WAIT_W     = cnt_w(IMEM_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(IMEM_MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              to_clr, to_en, to_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Held at zero while idle, so every grant starts counting from 0.
  assign to_clr = (state == IDLE);
  assign to_en  = (state != IDLE) && !mem_ready;

  mem_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (to_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (to_en),
    .expired  (to_expired)
  );

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    imem_rdata = '0;
    imem_ready = 1'b0;
    imem_err   = 1'b0;
    dmem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_err   = 1'b0;

    case (state)
      IDLE: begin
        if (imem_req && dmem_req) begin
          if (wait_cnt == WAIT_LIMIT) begin
            state_nxt = GRANT_I;
            wait_nxt  = '0;
          end else begin
            // wait_cnt is below the limit here, so the increment cannot wrap.
            state_nxt = GRANT_D;
            wait_nxt  = wait_cnt + WAIT_W'(1);
          end
        end else if (dmem_req) begin
          state_nxt = GRANT_D;
        end else if (imem_req) begin
          state_nxt = GRANT_I;
          wait_nxt  = '0;
        end
      end

      GRANT_I: begin
        // mem_req tracks the live request so a dropped request is not
        // presented to memory even for the cycle it is noticed in.
        mem_req  = imem_req;
        mem_be   = '1;
        mem_addr = imem_addr;
        if (!imem_req) begin
          state_nxt = IDLE;
        end else if (mem_ready) begin
          imem_ready = 1'b1;
          imem_rdata = mem_rdata;
          imem_err   = mem_err;
          state_nxt  = IDLE;
        end else if (to_expired) begin
          imem_ready = 1'b1;
          imem_err   = 1'b1;
          state_nxt  = IDLE;
        end
      end

      GRANT_D: begin
        mem_req   = dmem_req;
        mem_we    = dmem_we;
        mem_be    = dmem_be;
        mem_addr  = dmem_addr;
        mem_wdata = dmem_wdata;
        if (!dmem_req) begin
          state_nxt = IDLE;
        end else if (mem_ready) begin
          dmem_ready = 1'b1;
          dmem_rdata = mem_rdata;
          dmem_err   = mem_err;
          state_nxt  = IDLE;
        end else if (to_expired) begin
          dmem_ready = 1'b1;
          dmem_err   = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign owner = (state == GRANT_D) ? OWNER_DMEM : OWNER_IMEM;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic [DW-1:0] imem_rdata;
  logic          imem_ready, imem_err;
  logic          dmem_req = 1'b0;
  logic          dmem_we = 1'b0;
  logic [3:0]    dmem_be = '0;
  logic [AW-1:0] dmem_addr = '0;
  logic [DW-1:0] dmem_wdata = '0;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready, dmem_err;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          mem_err = 1'b0;
  logic          busy, owner;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .IMEM_MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_err(dmem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_err(mem_err), .busy(busy), .owner(owner)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the memory (0 none, 1 fetch, 2 data), how many cycles the
  // current grant has lasted, and how many contested rounds fetch has lost.
  int            m_own = 0;
  int            m_age = 0;
  int            m_loss = 0;
  logic          m_i_done = 1'b0, m_d_done = 1'b0;
  logic          e_mreq, e_we, e_busy, e_owner;
  logic [3:0]    e_be;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_ird, e_drd;
  logic          e_irdy, e_ierr, e_drdy, e_derr;

  task automatic model_step();
    logic own_req, done;
    if (rst) begin
      m_own = 0; m_age = 0; m_loss = 0; m_i_done = 1'b0; m_d_done = 1'b0;
      chk("rst_mem_side", {mem_req, mem_we, mem_be, busy, owner}, '0);
      chk("rst_ready_err", {imem_ready, imem_err, dmem_ready, dmem_err}, '0);
      chk("rst_rdata", {imem_rdata, dmem_rdata}, '0);
      return;
    end
    e_mreq = 0; e_we = 0; e_be = '0; e_addr = '0; e_wd = '0; e_busy = 0; e_owner = 0;
    e_irdy = 0; e_ierr = 0; e_ird = '0; e_drdy = 0; e_derr = 0; e_drd = '0;
    own_req = 0; done = 0;
    if (m_own != 0) begin
      e_busy  = 1;
      e_owner = (m_own == 2);
      own_req = (m_own == 2) ? dmem_req : imem_req;
      e_mreq  = own_req;
      done    = own_req && (mem_ready || (TO > 0 && m_age == TO - 1));
      if (m_own == 1) begin
        e_be = 4'hF; e_addr = imem_addr;
        e_irdy = done;
        e_ierr = done && (mem_ready ? mem_err : 1'b1);
        e_ird  = (done && mem_ready) ? mem_rdata : '0;
      end else begin
        e_we = dmem_we; e_be = dmem_be; e_addr = dmem_addr; e_wd = dmem_wdata;
        e_drdy = done;
        e_derr = done && (mem_ready ? mem_err : 1'b1);
        e_drd  = (done && mem_ready) ? mem_rdata : '0;
      end
    end
    chk("mdl_mem_req", mem_req, e_mreq);
    chk("mdl_mem_we", mem_we, e_we);
    chk("mdl_mem_be", mem_be, e_be);
    chk("mdl_mem_addr", mem_addr, e_addr);
    chk("mdl_mem_wdata", mem_wdata, e_wd);
    chk("mdl_imem_resp", {imem_ready, imem_err, imem_rdata}, {e_irdy, e_ierr, e_ird});
    chk("mdl_dmem_resp", {dmem_ready, dmem_err, dmem_rdata}, {e_drdy, e_derr, e_drd});
    chk("mdl_busy_owner", {busy, owner}, {e_busy, e_owner});
    m_i_done = e_irdy;
    m_d_done = e_drdy;
    if (m_own != 0) begin
      if (!own_req || done) m_own = 0;
      else m_age++;
    end else begin
      m_age = 0;
      if (imem_req && dmem_req) begin
        if (m_loss >= MW) begin m_own = 1; m_loss = 0; end
        else begin m_own = 2; m_loss++; end
      end else if (dmem_req) begin
        m_own = 2;
      end else if (imem_req) begin
        m_own = 1; m_loss = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(input int cycles, output int n, output logic [15:0] seq);
    n = 0;
    seq = '0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      #3;
      if (busy) begin
        if (n < 16) seq[n] = owner;
        n++;
      end
    end
  endtask

  task automatic drive_random(input logic stall);
    if (!imem_req) begin
      if ($urandom_range(0, 99) < 40) begin imem_req = 1; imem_addr = $urandom; end
    end else if (m_i_done) begin
      if ($urandom_range(0, 1) == 0) imem_req = 0;
      else imem_addr = $urandom;
    end else if ($urandom_range(0, 199) == 0) begin
      imem_req = 0;
    end
    if (!dmem_req) begin
      if ($urandom_range(0, 99) < 40) begin
        dmem_req = 1; dmem_we = 1'($urandom); dmem_be = 4'($urandom);
        dmem_addr = $urandom; dmem_wdata = $urandom;
      end
    end else if (m_d_done) begin
      if ($urandom_range(0, 1) == 0) dmem_req = 0;
      else begin
        dmem_we = 1'($urandom); dmem_be = 4'($urandom);
        dmem_addr = $urandom; dmem_wdata = $urandom;
      end
    end else if ($urandom_range(0, 199) == 0) begin
      dmem_req = 0;
    end
    mem_ready = stall ? 1'b0 : ($urandom_range(0, 99) < 45);
    mem_err   = ($urandom_range(0, 4) == 0);
    mem_rdata = $urandom;
  endtask

  int          n;
  logic [15:0] seq;
  logic        stall;

  initial begin
    #2;
    chk("reset_outputs", {mem_req, busy, owner, imem_ready, dmem_ready, mem_addr}, '0);
    tick(); tick();
    rst = 0;

    // Single fetch, memory answers on the third granted cycle.
    tick(); imem_req = 1; imem_addr = 32'h100; #3;
    chk("t1_no_mem_req_in_arb", mem_req, 0);
    tick(); #3;
    chk("t1_mem_req_rise", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_be_we", {mem_be, mem_we}, 5'b11110);
    tick(); #3;
    chk("t1_wait_no_ready", imem_ready, 0);
    tick(); mem_ready = 1; mem_rdata = 32'hDEADBEEF; #3;
    chk("t1_imem_resp", {imem_ready, imem_err, imem_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    chk("t1_dmem_quiet", dmem_ready, 0);
    tick(); imem_req = 0; mem_ready = 0; mem_rdata = 0; #3;
    chk("t1_single_pulse", {imem_ready, busy}, 2'b00);

    // Both requesting continuously, one-cycle memory.
    tick(); imem_req = 1; imem_addr = 32'h200; dmem_req = 1; dmem_we = 0; dmem_be = 4'hF;
    dmem_addr = 32'h1000; mem_ready = 1; mem_rdata = 32'h1234;
    grab(20, n, seq);
    chk("t2_grant_count", n, 10);
    chk("t2_grant_order", seq[9:0], 10'b0111101111);
    tick(); imem_req = 0; dmem_req = 0; mem_ready = 0;

    // Byte store.
    tick(); dmem_req = 1; dmem_we = 1; dmem_be = 4'b0100; dmem_addr = 32'h2004;
    dmem_wdata = 32'h00AB0000;
    tick(); #3;
    chk("t3_store_bus", {mem_req, mem_we, mem_be, mem_addr, mem_wdata},
        {1'b1, 1'b1, 4'b0100, 32'h2004, 32'h00AB0000});
    tick(); mem_ready = 1; #3;
    chk("t3_store_ready", {dmem_ready, imem_ready, dmem_err}, 3'b100);
    tick(); dmem_req = 0; dmem_we = 0; mem_ready = 0; #3;
    chk("t3_store_single_pulse", dmem_ready, 0);

    // Timeout with a late memory response.
    tick(); dmem_req = 1; dmem_be = 4'hF; dmem_addr = 32'h3000; mem_rdata = 32'hCAFEF00D;
    for (int g = 1; g <= 8; g++) begin
      tick(); #3;
      if (g < 8) chk("t4_no_early_ready", dmem_ready, 0);
      else chk("t4_timeout_resp", {dmem_ready, dmem_err, dmem_rdata, mem_req},
               {1'b1, 1'b1, 32'h0, 1'b1});
    end
    tick(); dmem_req = 0; #3;
    chk("t4_idle_after_timeout", {busy, mem_req}, 2'b00);
    tick(); mem_ready = 1; #3;
    chk("t4_late_ready_ignored", {dmem_ready, imem_ready, busy}, 3'b000);
    tick(); mem_ready = 0; mem_rdata = 0;

    // Memory error, then a normal data transaction.
    tick(); imem_req = 1; imem_addr = 32'h300;
    tick(); mem_ready = 1; mem_err = 1; mem_rdata = 32'h55AA55AA; #3;
    chk("t5_err_resp", {imem_ready, imem_err, imem_rdata, dmem_err},
        {1'b1, 1'b1, 32'h55AA55AA, 1'b0});
    tick(); imem_req = 0; mem_ready = 0; mem_err = 0; dmem_req = 1; dmem_addr = 32'h400; #3;
    chk("t5_idle", busy, 0);
    tick(); #3;
    chk("t5_next_grant", {busy, owner, mem_addr}, {1'b1, 1'b1, 32'h400});
    tick(); mem_ready = 1; mem_rdata = 32'h77; #3;
    chk("t5_next_resp", {dmem_ready, dmem_err, dmem_rdata}, {1'b1, 1'b0, 32'h77});
    tick(); dmem_req = 0; mem_ready = 0;

    // Reset in the middle of a data grant.
    tick(); imem_req = 1; dmem_req = 1; imem_addr = 32'h500; dmem_addr = 32'h600; mem_ready = 1;
    grab(4, n, seq);
    chk("t6_pre_grants", {n[7:0], seq[1:0]}, {8'd2, 2'b11});
    tick(); #1;
    chk("t6_in_grant_d", {busy, owner, dmem_ready}, 3'b111);
    #1 rst = 1;
    #1;
    chk("t6_async_drop", {mem_req, busy, dmem_ready, imem_ready, owner}, 5'b00000);
    tick(); tick(); rst = 0;
    grab(10, n, seq);
    chk("t6_post_grant_count", n, 5);
    chk("t6_post_order", seq[4:0], 5'b01111);
    tick(); imem_req = 0; dmem_req = 0; mem_ready = 0;

    // Random traffic against the model.
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 64 == 0) stall = ($urandom_range(0, 4) == 0);
      drive_random(stall);
    end
    tick(); imem_req = 0; dmem_req = 0; mem_ready = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
